// File: rtl/fp_pkg.sv
// Shared FP-stage definitions: field widths, exponent constants, int32 limits
// and the converter state encoding.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ROUND,
        ST_DONE
    } cvt_state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single unpacker: splits the fields, restores the
// hidden bit and classifies zero/denormal, infinity and NaN.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       fp_i,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [FRAC_W-1:0] frac_o,
    output logic [FRAC_W:0]   mant_o,
    output logic              is_zero_or_denorm_o,
    output logic              is_inf_o,
    output logic              is_nan_o
);

    logic expAllOnes;
    logic fracZero;

    assign sign_o     = fp_i[31];
    assign exp_o      = fp_i[30:23];
    assign frac_o     = fp_i[22:0];
    assign mant_o     = {1'b1, fp_i[22:0]};
    assign expAllOnes = (fp_i[30:23] == EXP_W'(EXP_MAX));
    assign fracZero   = (fp_i[22:0] == '0);

    assign is_zero_or_denorm_o = (fp_i[30:23] == '0);
    assign is_inf_o            = expAllOnes && fracZero;
    assign is_nan_o            = expAllOnes && !fracZero;

endmodule

// File: rtl/fp_to_int_seq.sv
// Multi-cycle single-precision to int32 converter (cvt.w.s): aligns the
// mantissa one bit per cycle, then rounds to nearest-even.
module fp_to_int_seq
    import fp_pkg::*;
#(
    parameter int          RSHIFT_CAP = 25,
    parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] fp_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] int_out,
    output logic        invalid,
    output logic        inexact
);

    localparam int CNT_W     = $clog2(RSHIFT_CAP + 1);
    localparam int LEFT_BASE = EXP_BIAS + FRAC_W;
    localparam int SAT_EXP   = EXP_BIAS + 31;

    logic              inSign;
    logic [EXP_W-1:0]  inExp;
    logic [FRAC_W-1:0] inFrac;
    logic [FRAC_W:0]   inMant;
    logic              inZeroDen;
    logic              inInf;
    logic              inNan;

    fp_unpack u_unpack (
        .fp_i                (fp_in),
        .sign_o              (inSign),
        .exp_o               (inExp),
        .frac_o              (inFrac),
        .mant_o              (inMant),
        .is_zero_or_denorm_o (inZeroDen),
        .is_inf_o            (inInf),
        .is_nan_o            (inNan)
    );

    cvt_state_t        state_q;
    logic [31:0]       mag_q;
    logic              guard_q;
    logic              sticky_q;
    logic              left_q;
    logic              sign_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [31:0]       int_q;
    logic              invalid_q;
    logic              inexact_q;

    logic              tooBig;
    logic              leftMode;
    logic [EXP_W-1:0]  leftDist;
    logic [EXP_W-1:0]  rightDist;
    logic [CNT_W-1:0]  cnt_d;
    logic [31:0]       satResult;
    logic              roundInc;
    logic [31:0]       roundMag;
    logic [31:0]       roundOut;

    // -2^31 (e==158, negative, zero fraction) is the only e==158 value that fits.
    always_comb begin
        tooBig    = (inExp > EXP_W'(SAT_EXP)) ||
                    ((inExp == EXP_W'(SAT_EXP)) && !(inSign && (inFrac == '0)));
        leftMode  = (inExp >= EXP_W'(LEFT_BASE));
        leftDist  = inExp - EXP_W'(LEFT_BASE);
        rightDist = EXP_W'(LEFT_BASE) - inExp;
        if (leftMode)
            cnt_d = CNT_W'(leftDist);
        else if (rightDist > EXP_W'(RSHIFT_CAP))
            cnt_d = CNT_W'(RSHIFT_CAP);
        else
            cnt_d = CNT_W'(rightDist);
        satResult = inSign ? INT32_MIN : INT32_MAX;
        roundInc  = guard_q & (sticky_q | mag_q[0]);
        roundMag  = mag_q + {31'b0, roundInc};
        roundOut  = sign_q ? (-roundMag) : roundMag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mag_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            left_q    <= 1'b0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            int_q     <= '0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q   <= 1'b1;
                        sign_q   <= inSign;
                        mag_q    <= {8'b0, inMant};
                        guard_q  <= 1'b0;
                        sticky_q <= 1'b0;
                        left_q   <= leftMode;
                        cnt_q    <= cnt_d;
                        if (inNan) begin
                            int_q     <= NAN_RESULT;
                            invalid_q <= 1'b1;
                            inexact_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else if (inInf || tooBig) begin
                            int_q     <= satResult;
                            invalid_q <= 1'b1;
                            inexact_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else if (inZeroDen) begin
                            int_q     <= '0;
                            invalid_q <= 1'b0;
                            inexact_q <= (inFrac != '0);
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_ROUND;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (left_q) begin
                            mag_q <= {mag_q[30:0], 1'b0};
                        end else begin
                            sticky_q <= sticky_q | guard_q;
                            guard_q  <= mag_q[0];
                            mag_q    <= {1'b0, mag_q[31:1]};
                        end
                    end
                end
                ST_ROUND: begin
                    int_q     <= roundOut;
                    inexact_q <= guard_q | sticky_q;
                    invalid_q <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign int_out = int_q;
    assign invalid = invalid_q;
    assign inexact = inexact_q;

endmodule
